// File: rtl/te_channel_sel_ctrl_if.sv
// Pixel-side valid/ready bundle for the channel-select controller.
// master drives pixels in and accepts bundles out; slave is the controller.
`timescale 1ns/1ps
interface te_channel_sel_ctrl_if #(
  parameter int PIX_W = 8,
  parameter int INV_W = 14
);
  logic             in_valid;
  logic             in_ready;
  logic [PIX_W-1:0] F_R;
  logic [PIX_W-1:0] F_G;
  logic [PIX_W-1:0] F_B;
  logic             out_valid;
  logic             out_ready;
  logic [PIX_W-1:0] o_F_R;
  logic [PIX_W-1:0] o_F_G;
  logic [PIX_W-1:0] o_F_B;
  logic [INV_W-1:0] o_Inv_AR;
  logic [INV_W-1:0] o_Inv_AG;
  logic [INV_W-1:0] o_Inv_AB;
  logic [1:0]       sel;

  modport master (
    output in_valid,
    output F_R,
    output F_G,
    output F_B,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  o_F_R,
    input  o_F_G,
    input  o_F_B,
    input  o_Inv_AR,
    input  o_Inv_AG,
    input  o_Inv_AB,
    input  sel
  );

  modport slave (
    input  in_valid,
    input  F_R,
    input  F_G,
    input  F_B,
    input  out_ready,
    output in_ready,
    output out_valid,
    output o_F_R,
    output o_F_G,
    output o_F_B,
    output o_Inv_AR,
    output o_Inv_AG,
    output o_Inv_AB,
    output sel
  );
endinterface

// File: rtl/te_channel_sel_ctrl.sv
// Channel-select controller: sel = argmin(F_c * Inv_A_c) over a
// 3-stage stallable pipeline with frame-synchronous Inv_A double buffer.
`timescale 1ns/1ps
module te_channel_sel_ctrl #(
  parameter int PIX_W = 8,
  parameter int INV_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             atm_valid,
  input  logic [INV_W-1:0] Inv_AR,
  input  logic [INV_W-1:0] Inv_AG,
  input  logic [INV_W-1:0] Inv_AB,
  input  logic             frame_start,
  output logic             atm_loaded,
  te_channel_sel_ctrl_if.slave pix
);

  localparam int P_W = PIX_W + INV_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } pix_t;

  typedef struct packed {
    logic [INV_W-1:0] r;
    logic [INV_W-1:0] g;
    logic [INV_W-1:0] b;
  } inv_t;

  typedef struct packed {
    logic [P_W-1:0] r;
    logic [P_W-1:0] g;
    logic [P_W-1:0] b;
  } prod_t;

  logic [1:0] state_q;
  logic [1:0] state_d;
  inv_t       pend_q;
  inv_t       pend_d;
  inv_t       act_q;
  inv_t       act_d;
  logic       pflag_q;
  logic       pflag_d;
  inv_t       inv_new;
  pix_t       f_in;

  logic       adv;
  logic       s1_v_q;
  pix_t       s1_f_q;
  inv_t       s1_a_q;
  logic       s2_v_q;
  pix_t       s2_f_q;
  inv_t       s2_a_q;
  prod_t      s2_p_q;
  logic       s3_v_q;
  pix_t       s3_f_q;
  inv_t       s3_a_q;
  logic [1:0] s3_sel_q;

  prod_t      p_d;
  logic [1:0] sel_d;
  logic       r_win;
  logic       g_win;
  logic       b_win;

  assign inv_new = {Inv_AR, Inv_AG, Inv_AB};
  assign f_in    = {pix.F_R, pix.F_G, pix.F_B};

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    act_d   = act_q;
    pflag_d = pflag_q;
    unique case (state_q)
      ST_IDLE: begin
        if (atm_valid && frame_start) begin
          act_d   = inv_new;
          state_d = ST_RUN;
        end else if (atm_valid) begin
          pend_d  = inv_new;
          pflag_d = 1'b1;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED, ST_RUN: begin
        if (frame_start) begin
          // same-cycle atm_valid wins over anything still pending
          if (atm_valid) begin
            act_d = inv_new;
          end else if (pflag_q) begin
            act_d = pend_q;
          end
          pflag_d = 1'b0;
          state_d = ST_RUN;
        end else if (atm_valid) begin
          pend_d  = inv_new;
          pflag_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      act_q   <= '0;
      pflag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      pflag_q <= pflag_d;
    end
  end

  assign atm_loaded   = (state_q == ST_RUN);
  assign adv          = !s3_v_q || pix.out_ready;
  assign pix.in_ready = atm_loaded && adv;

  always_comb begin
    p_d.r = P_W'(s1_f_q.r) * P_W'(s1_a_q.r);
    p_d.g = P_W'(s1_f_q.g) * P_W'(s1_a_q.g);
    p_d.b = P_W'(s1_f_q.b) * P_W'(s1_a_q.b);
  end

  // mutually exclusive wins encode the lowest-index tie rule
  assign r_win = (s2_p_q.r <= s2_p_q.g) && (s2_p_q.r <= s2_p_q.b);
  assign g_win = !r_win && (s2_p_q.g <= s2_p_q.b);
  assign b_win = !r_win && !g_win;

  always_comb begin
    sel_d = 2'b00;
    unique case (1'b1)
      r_win:   sel_d = 2'b00;
      g_win:   sel_d = 2'b01;
      b_win:   sel_d = 2'b10;
      default: sel_d = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v_q   <= 1'b0;
      s1_f_q   <= '0;
      s1_a_q   <= '0;
      s2_v_q   <= 1'b0;
      s2_f_q   <= '0;
      s2_a_q   <= '0;
      s2_p_q   <= '0;
      s3_v_q   <= 1'b0;
      s3_f_q   <= '0;
      s3_a_q   <= '0;
      s3_sel_q <= 2'b00;
    end else if (adv) begin
      s1_v_q   <= pix.in_valid && atm_loaded;
      s1_f_q   <= f_in;
      s1_a_q   <= act_q;
      s2_v_q   <= s1_v_q;
      s2_f_q   <= s1_f_q;
      s2_a_q   <= s1_a_q;
      s2_p_q   <= p_d;
      s3_v_q   <= s2_v_q;
      s3_f_q   <= s2_f_q;
      s3_a_q   <= s2_a_q;
      s3_sel_q <= sel_d;
    end
  end

  assign pix.out_valid = s3_v_q;
  assign pix.o_F_R     = s3_f_q.r;
  assign pix.o_F_G     = s3_f_q.g;
  assign pix.o_F_B     = s3_f_q.b;
  assign pix.o_Inv_AR  = s3_a_q.r;
  assign pix.o_Inv_AG  = s3_a_q.g;
  assign pix.o_Inv_AB  = s3_a_q.b;
  assign pix.sel       = s3_sel_q;

endmodule

// File: tb/tb_te_channel_sel_ctrl.sv
// Bench for te_channel_sel_ctrl: scoreboard model checked every cycle,
// directed literal cases, then randomized traffic.
`timescale 1ns/1ps
module tb_te_channel_sel_ctrl;
  localparam int PIX_W = 8;
  localparam int INV_W = 14;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic atm_valid = 1'b0;
  logic frame_start = 1'b0;
  logic [INV_W-1:0] Inv_AR = '0;
  logic [INV_W-1:0] Inv_AG = '0;
  logic [INV_W-1:0] Inv_AB = '0;
  logic atm_loaded;

  te_channel_sel_ctrl_if #(.PIX_W(PIX_W), .INV_W(INV_W)) pix();

  te_channel_sel_ctrl #(.PIX_W(PIX_W), .INV_W(INV_W)) dut (
    .clk(clk),
    .rst(rst),
    .atm_valid(atm_valid),
    .Inv_AR(Inv_AR),
    .Inv_AG(Inv_AG),
    .Inv_AB(Inv_AB),
    .frame_start(frame_start),
    .atm_loaded(atm_loaded),
    .pix(pix)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  typedef struct {
    longint f[3];
    longint a[3];
    longint sel;
  } exp_t;

  exp_t   sb[$];
  int     m_phase;
  bit     m_pflag;
  longint m_act[3];
  longint m_pend[3];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint argmin(input longint f[3], input longint a[3]);
    longint best;
    best = 0;
    for (int c = 1; c < 3; c++)
      if (f[c] * a[c] < f[best] * a[best]) best = c;
    return best;
  endfunction

  always @(negedge clk) begin
    exp_t   e;
    longint nw[3];
    if (!rst) begin
      sb.delete();
      m_phase = 0;
      m_pflag = 0;
      m_act   = '{0, 0, 0};
      m_pend  = '{0, 0, 0};
      chk("rst_out_valid", pix.out_valid, 0);
      chk("rst_in_ready", pix.in_ready, 0);
      chk("rst_sel", pix.sel, 0);
    end else begin
      chk("atm_loaded", atm_loaded, (m_phase == 2) ? 1 : 0);
      chk("in_ready", pix.in_ready,
          (m_phase == 2 && (!pix.out_valid || pix.out_ready)) ? 1 : 0);
      if (pix.out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          e = sb[0];
          chk("out_sel", pix.sel, e.sel);
          chk("out_F", {pix.o_F_R, pix.o_F_G, pix.o_F_B},
              (e.f[0] << 16) | (e.f[1] << 8) | e.f[2]);
          chk("out_Inv", {pix.o_Inv_AR, pix.o_Inv_AG, pix.o_Inv_AB},
              (e.a[0] << 28) | (e.a[1] << 14) | e.a[2]);
          if (pix.out_ready) begin
            void'(sb.pop_front());
            n_out++;
          end
        end
      end
      if (pix.in_valid && pix.in_ready) begin
        e.f = '{longint'(pix.F_R), longint'(pix.F_G), longint'(pix.F_B)};
        e.a = m_act;
        e.sel = argmin(e.f, e.a);
        sb.push_back(e);
      end
      nw = '{longint'(Inv_AR), longint'(Inv_AG), longint'(Inv_AB)};
      if (m_phase == 0) begin
        if (atm_valid && frame_start) begin
          m_act = nw;
          m_phase = 2;
        end else if (atm_valid) begin
          m_pend = nw;
          m_pflag = 1;
          m_phase = 1;
        end
      end else if (frame_start) begin
        if (atm_valid) m_act = nw;
        else if (m_pflag) m_act = m_pend;
        m_pflag = 0;
        m_phase = 2;
      end else if (atm_valid) begin
        m_pend = nw;
        m_pflag = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic atm(input int r, input int g, input int b, input bit fs);
    Inv_AR = INV_W'(r);
    Inv_AG = INV_W'(g);
    Inv_AB = INV_W'(b);
    atm_valid = 1'b1;
    frame_start = fs;
    tick();
    atm_valid = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic fstart();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic send1(input int r, input int g, input int b,
                       input bit fs, input logic [1:0] exp_sel,
                       input string nm);
    int n;
    bit got;
    pix.out_ready = 1'b1;
    repeat (4) tick();
    pix.in_valid = 1'b1;
    pix.F_R = PIX_W'(r);
    pix.F_G = PIX_W'(g);
    pix.F_B = PIX_W'(b);
    frame_start = fs;
    n = 0;
    got = 0;
    repeat (10) begin
      @(negedge clk);
      if (pix.out_valid) begin
        got = 1;
        break;
      end
      n++;
      tick();
      pix.in_valid = 1'b0;
      frame_start = 1'b0;
    end
    chk({nm, "_got"}, got, 1);
    chk({nm, "_lat"}, n, 3);
    chk({nm, "_sel"}, pix.sel, exp_sel);
    tick();
  endtask

  initial begin
    int i;
    int cyc;
    int base;
    bit acc;
    pix.in_valid  = 1'b0;
    pix.out_ready = 1'b1;
    pix.F_R = '0;
    pix.F_G = '0;
    pix.F_B = '0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    pix.in_valid = 1'b1;
    pix.F_R = 8'd7;
    repeat (5) tick();
    @(negedge clk);
    chk("idle_out_valid", pix.out_valid, 0);
    chk("idle_in_ready", pix.in_ready, 0);
    chk("idle_atm_loaded", atm_loaded, 0);
    chk("idle_sel", pix.sel, 0);
    tick();
    pix.in_valid = 1'b0;

    fstart();
    @(negedge clk);
    chk("fs_in_idle_ignored", atm_loaded, 0);
    tick();
    atm(4096, 2048, 1024, 0);
    @(negedge clk);
    chk("armed_not_loaded", atm_loaded, 0);
    tick();
    fstart();
    send1(100, 100, 100, 0, 2'b10, "t2");
    chk("t2_invB", pix.o_Inv_AB, 1024);

    atm(2048, 2048, 2048, 1);
    send1(50, 50, 50, 0, 2'b00, "t3a");
    send1(60, 50, 50, 0, 2'b01, "t3b");
    send1(60, 60, 50, 0, 2'b10, "t3c");

    base = n_out;
    i = 0;
    cyc = 0;
    pix.in_valid = 1'b1;
    while (i < 8 && cyc < 200) begin
      pix.F_R = PIX_W'(10 + i);
      pix.F_G = PIX_W'(200 - i * 20);
      pix.F_B = PIX_W'(90);
      pix.out_ready = !(cyc >= 4 && cyc < 9);
      @(negedge clk);
      acc = pix.in_ready;
      if (cyc == 7) chk("t4_stall_in_ready", pix.in_ready, 0);
      tick();
      cyc++;
      if (acc) i++;
    end
    pix.in_valid = 1'b0;
    pix.out_ready = 1'b1;
    repeat (6) tick();
    chk("t4_count", n_out - base, 8);

    atm(1024, 2048, 4096, 1);
    send1(100, 100, 100, 0, 2'b00, "t5a");
    atm(4096, 2048, 1024, 0);
    send1(100, 100, 100, 0, 2'b00, "t5b");
    send1(100, 100, 100, 1, 2'b00, "t5c");
    send1(100, 100, 100, 0, 2'b10, "t5d");

    pix.in_valid = 1'b1;
    repeat (3) tick();
    pix.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("t6_rst_out_valid", pix.out_valid, 0);
    repeat (2) tick();
    rst = 1'b1;
    pix.in_valid = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk("t6_post_in_ready", pix.in_ready, 0);
    chk("t6_post_out_valid", pix.out_valid, 0);
    tick();
    pix.in_valid = 1'b0;
    atm(1024, 1024, 1024, 0);
    fstart();
    send1(9, 8, 7, 0, 2'b10, "t6_recover");

    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      pix.in_valid  = ($urandom_range(0, 9) < 7);
      pix.out_ready = ($urandom_range(0, 3) != 0);
      pix.F_R = PIX_W'($urandom);
      pix.F_G = PIX_W'($urandom);
      pix.F_B = PIX_W'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        pix.F_G = pix.F_R;
        pix.F_B = pix.F_R;
      end
      atm_valid   = ($urandom_range(0, 19) == 0);
      frame_start = ($urandom_range(0, 19) == 0);
      Inv_AR = INV_W'($urandom);
      Inv_AG = ($urandom_range(0, 1) != 0) ? Inv_AR : INV_W'($urandom);
      Inv_AB = INV_W'($urandom);
      tick();
    end
    pix.in_valid = 1'b0;
    atm_valid = 1'b0;
    frame_start = 1'b0;
    pix.out_ready = 1'b1;
    repeat (8) tick();
    chk("final_drain", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
